// File: rtl/prueba_if.sv
// Tile pin bundle for the accumulator ALU.
// The chip wrapper drives the master side; the tile is the slave side.
interface prueba_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/prueba.sv
// 8-bit accumulator ALU tile: A <= f(A, B) on each enabled go cycle.
// Flags {V,N,Z,C} are registered alongside A and appear on uio_out[7:4].
module prueba (
    input  logic     clk,
    input  logic     rst_n,
    prueba_if.slave  bus
);
    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_SHL  = 3'd6,
        OP_SHR  = 3'd7
    } op_e;

    logic [7:0]  acc;
    logic [3:0]  flg;
    logic [7:0]  b;
    logic [2:0]  sh;
    op_e         op;
    logic        go;
    logic [8:0]  sum;
    logic [8:0]  dif;
    logic [15:0] shl;
    logic [15:0] shr;
    logic [7:0]  res;
    logic        c;
    logic        v;
    logic        unused_ok;

    assign b   = bus.ui_in;
    assign sh  = b[2:0];
    assign op  = op_e'(bus.uio_in[2:0]);
    assign go  = bus.uio_in[3];
    assign sum = {1'b0, acc} + {1'b0, b};
    assign dif = {1'b0, acc} - {1'b0, b};
    // Widened shifts keep the last bit shifted out next to the result.
    assign shl = {8'h00, acc} << sh;
    assign shr = {acc, 8'h00} >> sh;

    assign unused_ok = &{1'b0, bus.uio_in[7:4]};

    always_comb begin
        res = 8'h00;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op)
            OP_LOAD: res = b;
            OP_ADD: begin
                res = sum[7:0];
                c   = sum[8];
                v   = (acc[7] == b[7]) && (sum[7] != acc[7]);
            end
            OP_SUB: begin
                res = dif[7:0];
                c   = dif[8];
                v   = (acc[7] != b[7]) && (dif[7] != acc[7]);
            end
            OP_AND: res = acc & b;
            OP_OR:  res = acc | b;
            OP_XOR: res = acc ^ b;
            OP_SHL: begin
                res = shl[7:0];
                c   = shl[8];
            end
            OP_SHR: begin
                res = shr[15:8];
                c   = shr[7];
            end
            default: res = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 8'h00;
            flg <= 4'b0010;
        end else if (bus.ena && go) begin
            acc <= res;
            flg <= {v, res[7], (res == 8'h00), c};
        end
    end

    assign bus.uo_out  = acc;
    assign bus.uio_out = {flg, 4'h0};
    assign bus.uio_oe  = 8'hF0;
endmodule

// File: tb/tb_prueba.sv
// Self-checking bench for prueba: directed tile scenarios plus
// randomized operations scored against an arithmetic reference model.
module tb_prueba;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] ma;
    logic [3:0] mf;

    always #5 clk = ~clk;

    prueba_if io ();

    prueba dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (io.slave)
    );

    function automatic int sgn(input logic [7:0] x);
        return (x > 8'd127) ? int'(x) - 256 : int'(x);
    endfunction

    // Reference model: plain integer arithmetic on the opcode rules.
    task automatic model(input logic [2:0] op, input logic [7:0] b);
        int r, c, v, s, t;
        c = 0;
        v = 0;
        s = int'(b[2:0]);
        case (op)
            3'd0: r = int'(b);
            3'd1: begin
                t = int'(ma) + int'(b);
                r = t % 256;
                c = (t > 255) ? 1 : 0;
                t = sgn(ma) + sgn(b);
                v = (t > 127 || t < -128) ? 1 : 0;
            end
            3'd2: begin
                t = int'(ma) - int'(b);
                r = (t + 256) % 256;
                c = (int'(ma) < int'(b)) ? 1 : 0;
                t = sgn(ma) - sgn(b);
                v = (t > 127 || t < -128) ? 1 : 0;
            end
            3'd3: r = int'(ma & b);
            3'd4: r = int'(ma | b);
            3'd5: r = int'(ma ^ b);
            3'd6: begin
                r = (int'(ma) * (1 << s)) % 256;
                c = (s == 0) ? 0 : ((int'(ma) >> (8 - s)) & 1);
            end
            default: begin
                r = int'(ma) / (1 << s);
                c = (s == 0) ? 0 : ((int'(ma) >> (s - 1)) & 1);
            end
        endcase
        ma = r[7:0];
        mf = {v != 0, r >= 128, r == 0, c != 0};
    endtask

    task automatic step(input logic [2:0] op, input logic [7:0] b,
                        input logic go, input logic en);
        io.ui_in  = b;
        io.uio_in = {4'($urandom), go, op};
        io.ena    = en;
        @(posedge clk);
        if (go && en) model(op, b);
        #1;
    endtask

    task automatic test_reset();
        io.ena = 1'b0;
        io.ui_in = 8'h00;
        io.uio_in = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({io.uo_out, io.uio_out} !== 16'h0020) begin
            failures++;
            $display("FAIL reset_state got=%h required=0020",
                     {io.uo_out, io.uio_out});
        end
        checks++;
        if (io.uio_oe !== 8'hF0) begin
            failures++;
            $display("FAIL reset_oe got=%h required=F0", io.uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ma = 8'h00;
        mf = 4'b0010;
    endtask

    task automatic test_directed();
        logic [2:0]  op[12] = '{0, 1, 1, 0, 2, 2, 0, 5, 3, 0, 6, 7};
        logic [7:0]  bv[12] = '{8'h7F, 8'h01, 8'h80, 8'h05, 8'h05, 8'h01,
                                8'hF0, 8'hFF, 8'h00, 8'h81, 8'h01, 8'h02};
        logic [15:0] ex[12] = '{16'h7F00, 16'h80C0, 16'h00B0, 16'h0500,
                                16'h0020, 16'hFF50, 16'hF040, 16'h0F00,
                                16'h0020, 16'h8140, 16'h0210, 16'h0030};
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            step(op[i], bv[i], 1'b1, 1'b1);
            checks++;
            if ({io.uo_out, io.uio_out} !== ex[i]) begin
                failures++;
                $display("FAIL directed_%0d got=%h required=%h",
                         i, {io.uo_out, io.uio_out}, ex[i]);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            logic g;
            g = i[0];
            step(3'($urandom), 8'($urandom), g, ~g);
            checks++;
            if ({io.uo_out, io.uio_out} !== 16'h0030) begin
                failures++;
                $display("FAIL hold_%0d got=%h required=0030",
                         i, {io.uo_out, io.uio_out});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(3'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));
            checks++;
            if ({io.uo_out, io.uio_out} !== {ma, mf, 4'h0}) begin
                failures++;
                $display("FAIL random_%0d got=%h required=%h",
                         i, {io.uo_out, io.uio_out}, {ma, mf, 4'h0});
            end
        end
    endtask

    task automatic test_async_reset();
        step(3'd0, 8'hA5, 1'b1, 1'b1);
        io.uio_in = 8'h09;
        io.ui_in = 8'h11;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({io.uo_out, io.uio_out} !== 16'h0020) begin
            failures++;
            $display("FAIL async_reset got=%h required=0020",
                     {io.uo_out, io.uio_out});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({io.uo_out, io.uio_out} !== 16'h0020) begin
            failures++;
            $display("FAIL reset_held got=%h required=0020",
                     {io.uo_out, io.uio_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ma = 8'h00;
        mf = 4'b0010;
        step(3'd1, 8'h11, 1'b1, 1'b1);
        checks++;
        if ({io.uo_out, io.uio_out} !== 16'h1100) begin
            failures++;
            $display("FAIL after_reset got=%h required=1100",
                     {io.uo_out, io.uio_out});
        end
        checks++;
        if (io.uio_oe !== 8'hF0) begin
            failures++;
            $display("FAIL oe_const got=%h required=F0", io.uio_oe);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
